// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: shares one APB RAM slave between two valid/ready requesters.
// Arbitration is round-robin. Each command runs as an APB SETUP/ACCESS transfer.
// Completion returns read data, or a timeout error when pready never arrives.
module apb_ram_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        r0_valid,
    input  logic        r0_write,
    input  logic [15:0] r0_addr,
    input  logic [15:0] r0_wdata,
    output logic        r0_ready,
    output logic        r0_rsp_valid,
    input  logic        r1_valid,
    input  logic        r1_write,
    input  logic [15:0] r1_addr,
    input  logic [15:0] r1_wdata,
    output logic        r1_ready,
    output logic        r1_rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [15:0] pwdata,
    input  logic [15:0] prdata,
    input  logic        pready,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [15:0] paddr_q, paddr_d;
    logic [15:0] pwdata_q, pwdata_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp0_q, rsp0_d;
    logic        rsp1_q, rsp1_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        win_s;
    logic        accept_s;

    // Round-robin winner selection and accept qualification (only in IDLE, never in reset)
    always_comb begin
        if (r0_valid && r1_valid) begin
            win_s = ~last_grant_q;
        end else if (r1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        accept_s = (state_q == ST_IDLE) && (r0_valid || r1_valid) && !preset;
    end

    assign r0_ready     = accept_s & ~win_s;
    assign r1_ready     = accept_s & win_s;
    assign r0_rsp_valid = rsp0_q;
    assign r1_rsp_valid = rsp1_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign psel         = psel_q;
    assign penable      = penable_q;
    assign pwrite       = pwrite_q;
    assign paddr        = paddr_q;
    assign pwdata       = pwdata_q;
    assign busy         = psel_q;

    // Next-state logic for the transfer FSM, APB controls and response registers
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        wait_cnt_d   = wait_cnt_q;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_SETUP;
                    grant_d      = win_s;
                    last_grant_d = win_s;
                    pwrite_d     = win_s ? r1_write : r0_write;
                    paddr_d      = win_s ? r1_addr  : r0_addr;
                    pwdata_d     = win_s ? r1_wdata : r0_wdata;
                    wait_cnt_d   = 8'd0;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                end else begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (pready) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rsp0_d    = ~grant_q;
                    rsp1_d    = grant_q;
                    rsp_err_d = 1'b0;
                    if (!pwrite_q) begin
                        rsp_rdata_d = prdata;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                end else if (wait_cnt_q == (TIMEOUT - 8'd1)) begin
                    // Slave never answered: abort and report the error, data untouched
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rsp0_d    = ~grant_q;
                    rsp1_d    = grant_q;
                    rsp_err_d = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= 16'h0000;
            pwdata_q     <= 16'h0000;
            rsp_rdata_q  <= 16'h0000;
            rsp_err_q    <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Testbench for apb_ram_arbiter: behavioural APB RAM slave with configurable wait
// states plus a transaction-level reference model (grant order, memory, latency).
module tb_apb_ram_arbiter;

    localparam logic [7:0] TO = 8'd4;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        r0_valid = 1'b0, r0_write = 1'b0;
    logic [15:0] r0_addr = 16'h0000, r0_wdata = 16'h0000;
    logic        r1_valid = 1'b0, r1_write = 1'b0;
    logic [15:0] r1_addr = 16'h0000, r1_wdata = 16'h0000;
    logic        r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid;
    logic        rsp_err, psel, penable, pwrite, pready, busy;
    logic [15:0] rsp_rdata, paddr, pwdata, prdata;

    int nvec = 0;
    int nerr = 0;

    apb_ram_arbiter #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .busy(busy)
    );

    always #5 pclk = ~pclk;

    // ---------------- APB RAM slave ----------------
    logic [15:0] slv_mem [256];
    bit          mem_init_done = 1'b0;
    int          ws_cfg = 0;
    bit          stall_all = 1'b0;
    int          acc_cnt = 0;
    logic        junk_rdy = 1'b0;
    logic [15:0] junk_data = 16'h0000;

    // Slave memory, wait-state counter and random noise on idle bus lines
    always @(posedge pclk) begin
        junk_rdy  <= ($urandom_range(0, 1) == 1);
        junk_data <= 16'($urandom);
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= 16'(i * 37 + 5);
            mem_init_done <= 1'b1;
        end else if (psel && penable && pready && pwrite) begin
            slv_mem[paddr[7:0]] <= pwdata;
        end
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign pready = (psel && penable) ? (!stall_all && acc_cnt == ws_cfg) : junk_rdy;
    assign prdata = (psel && penable && pready) ? slv_mem[paddr[7:0]] : junk_data;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [256];
    int          model_last = 1;
    logic [15:0] model_rdata = 16'h0000;

    function automatic int model_pick(bit v0, bit v1);
        if (v0 && v1) return (model_last == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    task automatic model_apply(input int w, input bit wr, input logic [15:0] a,
                               input logic [15:0] d, input bit timed_out);
        model_last = w;
        if (!timed_out) begin
            if (wr) ref_mem[a[7:0]] = d;
            else model_rdata = ref_mem[a[7:0]];
        end
    endtask

    // Drives one command set, then observes accept, the two APB phases and completion.
    // Entered and left in the low phase of the clock, in the completion cycle.
    task automatic issue(input bit v0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                         input bit v1, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                         output int who, output int wt, output int lat, output int acc,
                         output logic [15:0] rd, output logic er, output int rsp_who,
                         output bit both, output logic [35:0] snap1, output logic [35:0] snap2);
        r0_valid = v0; r0_write = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_write = w1; r1_addr = a1; r1_wdata = d1;
        who = -1; wt = 0; lat = 0; acc = 0; rd = 16'hxxxx; er = 1'bx;
        rsp_who = -1; both = 1'b0; snap1 = 36'h0; snap2 = 36'h0;
        while (who < 0 && wt < 20) begin
            #1;
            if (r0_ready && r1_ready) both = 1'b1;
            if (r0_ready) who = 0;
            else if (r1_ready) who = 1;
            else begin
                @(negedge pclk);
                wt++;
            end
        end
        if (who < 0) begin
            r0_valid = 1'b0;
            r1_valid = 1'b0;
            return;
        end
        @(negedge pclk);
        if (who == 0) begin
            r0_valid = 1'b0; r0_write = 1'($urandom_range(0, 1));
            r0_addr = 16'($urandom); r0_wdata = 16'($urandom);
        end else begin
            r1_valid = 1'b0; r1_write = 1'($urandom_range(0, 1));
            r1_addr = 16'($urandom); r1_wdata = 16'($urandom);
        end
        #1;
        snap1 = {psel, penable, busy, pwrite, paddr, pwdata};
        @(negedge pclk); #1;
        snap2 = {psel, penable, busy, pwrite, paddr, pwdata};
        lat = 2;
        while (lat < 40) begin
            if (psel && penable) acc++;
            @(negedge pclk);
            lat++;
            #1;
            if (r0_rsp_valid && r1_rsp_valid) both = 1'b1;
            if (r0_rsp_valid || r1_rsp_valid) begin
                rsp_who = r0_rsp_valid ? 0 : 1;
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        preset = 1'b1;
        r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 16'h0005;
        r1_valid = 1'b0;
        repeat (2) @(negedge pclk);
        #1;
        nvec++; if ({psel, penable, pwrite, busy, rsp_err, r0_rsp_valid, r1_rsp_valid} !== 7'b0) begin
            nerr++; $display("FAIL reset_ctrl: got %b exp 0000000", {psel, penable, pwrite, busy, rsp_err, r0_rsp_valid, r1_rsp_valid});
        end
        nvec++; if ({paddr, pwdata, rsp_rdata} !== 48'h0) begin
            nerr++; $display("FAIL reset_data: got %h exp 0", {paddr, pwdata, rsp_rdata});
        end
        nvec++; if ({r0_ready, r1_ready} !== 2'b00) begin
            nerr++; $display("FAIL reset_ready: got %b exp 00", {r0_ready, r1_ready});
        end
        preset = 1'b0;
        model_last = 1; model_rdata = 16'h0000;
        #1;
        nvec++; if (r0_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_release_ready: got %b exp 1", r0_ready);
        end
        r0_valid = 1'b0;
        @(negedge pclk); #1;
        nvec++; if ({psel, busy} !== 2'b00) begin
            nerr++; $display("FAIL reset_no_accept: got %b exp 00", {psel, busy});
        end
    endtask

    task automatic test_single();
        int who, wt, lat, acc, rw; logic [15:0] rd; logic er; bit both; logic [35:0] s1, s2;
        stall_all = 1'b0; ws_cfg = 0;
        issue(1'b1, 1'b1, 16'h0012, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0,
              who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(0, 1'b1, 16'h0012, 16'hBEEF, 1'b0);
        nvec++; if (who !== 0 || wt !== 0) begin
            nerr++; $display("FAIL single_wr_accept: got who=%0d wait=%0d exp 0 0", who, wt);
        end
        nvec++; if (s1 !== {4'b1011, 16'h0012, 16'hBEEF}) begin
            nerr++; $display("FAIL single_wr_setup: got %h exp %h", s1, {4'b1011, 16'h0012, 16'hBEEF});
        end
        nvec++; if (s2 !== {4'b1111, 16'h0012, 16'hBEEF}) begin
            nerr++; $display("FAIL single_wr_access: got %h exp %h", s2, {4'b1111, 16'h0012, 16'hBEEF});
        end
        nvec++; if (lat !== 3 || rw !== 0 || er !== 1'b0 || rd !== model_rdata) begin
            nerr++; $display("FAIL single_wr_rsp: got lat=%0d who=%0d err=%b rd=%h exp 3 0 0 %h", lat, rw, er, rd, model_rdata);
        end
        @(negedge pclk); #1;
        nvec++; if ({r0_rsp_valid, r1_rsp_valid, busy} !== 3'b000) begin
            nerr++; $display("FAIL single_pulse: got %b exp 000", {r0_rsp_valid, r1_rsp_valid, busy});
        end
        issue(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
              who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(0, 1'b0, 16'h0012, 16'h0000, 1'b0);
        nvec++; if (lat !== 3 || rw !== 0 || er !== 1'b0 || rd !== 16'hBEEF) begin
            nerr++; $display("FAIL single_rd: got lat=%0d who=%0d err=%b rd=%h exp 3 0 0 beef", lat, rw, er, rd);
        end
    endtask

    task automatic test_contention();
        int who, wt, lat, acc, rw, ew; logic [15:0] rd; logic er; bit both; logic [35:0] s1, s2;
        bit w0, w1; logic [15:0] a0, a1, d0, d1;
        stall_all = 1'b0; ws_cfg = 0;
        for (int i = 0; i < 10; i++) begin
            w0 = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            w1 = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            a0 = 16'($urandom) & 16'hF00F; a1 = 16'($urandom) & 16'hF00F;
            d0 = 16'($urandom); d1 = 16'($urandom);
            ew = model_pick(1'b1, 1'b1);
            issue(1'b1, w0, a0, d0, 1'b1, w1, a1, d1, who, wt, lat, acc, rd, er, rw, both, s1, s2);
            model_apply(ew, (ew == 0) ? w0 : w1, (ew == 0) ? a0 : a1, (ew == 0) ? d0 : d1, 1'b0);
            nvec++; if (who !== ew || rw !== ew || both !== 1'b0) begin
                nerr++; $display("FAIL contention_grant[%0d]: got grant=%0d rsp=%0d both=%b exp %0d", i, who, rw, both, ew);
            end
            nvec++; if (wt !== 0 || lat !== 3 || er !== 1'b0 || rd !== model_rdata) begin
                nerr++; $display("FAIL contention_rsp[%0d]: got wait=%0d lat=%0d err=%b rd=%h exp 0 3 0 %h", i, wt, lat, er, rd, model_rdata);
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    task automatic test_wait_states();
        int who, wt, lat, acc, rw, ew, m; logic [15:0] rd; logic er; bit both; logic [35:0] s1, s2;
        bit v0, v1, w0, w1; logic [15:0] a0, a1, d0, d1;
        stall_all = 1'b0; ws_cfg = 2;
        issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h00FF, 16'h1234,
              who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(1, 1'b1, 16'h00FF, 16'h1234, 1'b0);
        issue(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h00FF, 16'h0000,
              who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(1, 1'b0, 16'h00FF, 16'h0000, 1'b0);
        nvec++; if (rw !== 1 || lat !== 5 || rd !== 16'h1234 || er !== 1'b0) begin
            nerr++; $display("FAIL ws2_read: got who=%0d lat=%0d rd=%h err=%b exp 1 5 1234 0", rw, lat, rd, er);
        end
        for (int i = 0; i < 16; i++) begin
            m = $urandom_range(1, 3);
            v0 = m[0]; v1 = m[1];
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = 16'($urandom) & 16'hF00F; a1 = 16'($urandom) & 16'hF00F;
            d0 = 16'($urandom); d1 = 16'($urandom);
            ws_cfg = $urandom_range(0, int'(TO) - 1);
            ew = model_pick(v0, v1);
            issue(v0, w0, a0, d0, v1, w1, a1, d1, who, wt, lat, acc, rd, er, rw, both, s1, s2);
            model_apply(ew, (ew == 0) ? w0 : w1, (ew == 0) ? a0 : a1, (ew == 0) ? d0 : d1, 1'b0);
            nvec++; if (who !== ew || rw !== ew || both !== 1'b0) begin
                nerr++; $display("FAIL ws_grant[%0d]: got grant=%0d rsp=%0d both=%b exp %0d", i, who, rw, both, ew);
            end
            nvec++; if (lat !== 3 + ws_cfg || er !== 1'b0 || rd !== model_rdata) begin
                nerr++; $display("FAIL ws_rsp[%0d]: got lat=%0d err=%b rd=%h exp %0d 0 %h", i, lat, er, rd, 3 + ws_cfg, model_rdata);
            end
        end
    endtask

    task automatic test_timeout();
        int who, wt, lat, acc, rw; logic [15:0] rd; logic er; bit both; logic [35:0] s1, s2;
        logic [15:0] a;
        a = 16'h0040 | (16'($urandom) & 16'h000F);
        stall_all = 1'b1;
        issue(1'b1, 1'b0, a, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(0, 1'b0, a, 16'h0, 1'b1);
        nvec++; if (lat !== int'(TO) + 2 || acc !== int'(TO) || rw !== 0) begin
            nerr++; $display("FAIL timeout_rd_timing: got lat=%0d access=%0d who=%0d exp %0d %0d 0", lat, acc, rw, int'(TO) + 2, int'(TO));
        end
        nvec++; if (er !== 1'b1 || rd !== model_rdata) begin
            nerr++; $display("FAIL timeout_rd_rsp: got err=%b rd=%h exp 1 %h", er, rd, model_rdata);
        end
        issue(1'b1, 1'b1, a, 16'hC0DE, 1'b0, 1'b0, 16'h0, 16'h0, who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(0, 1'b1, a, 16'hC0DE, 1'b1);
        nvec++; if (er !== 1'b1 || lat !== int'(TO) + 2 || rd !== model_rdata) begin
            nerr++; $display("FAIL timeout_wr: got err=%b lat=%0d rd=%h exp 1 %0d %h", er, lat, rd, int'(TO) + 2, model_rdata);
        end
        @(negedge pclk); #1;
        nvec++; if ({r0_rsp_valid, rsp_err, psel} !== 3'b010 || rsp_rdata !== model_rdata) begin
            nerr++; $display("FAIL timeout_hold: got rsp/err/psel=%b rd=%h exp 010 %h", {r0_rsp_valid, rsp_err, psel}, rsp_rdata, model_rdata);
        end
        stall_all = 1'b0; ws_cfg = 0;
        issue(1'b1, 1'b0, a, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(0, 1'b0, a, 16'h0, 1'b0);
        nvec++; if (er !== 1'b0 || lat !== 3 || rd !== model_rdata) begin
            nerr++; $display("FAIL timeout_recover: got err=%b lat=%0d rd=%h exp 0 3 %h", er, lat, rd, model_rdata);
        end
    endtask

    task automatic test_mid_reset();
        int who, wt, lat, acc, rw, k; logic [15:0] rd; logic er; bit both, seen; logic [35:0] s1, s2;
        stall_all = 1'b0; ws_cfg = 2;
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 16'h0033; r1_wdata = 16'hA5A5;
        k = 0;
        #1;
        while (!r1_ready && k < 20) begin
            @(negedge pclk); k++; #1;
        end
        nvec++; if (r1_ready !== 1'b1) begin
            nerr++; $display("FAIL midrst_accept: got %b exp 1", r1_ready);
        end
        @(negedge pclk);
        r1_valid = 1'b0;
        @(negedge pclk); #1;
        nvec++; if ({psel, penable} !== 2'b11) begin
            nerr++; $display("FAIL midrst_access: got %b exp 11", {psel, penable});
        end
        preset = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
        @(negedge pclk); #1;
        nvec++; if ({psel, penable, busy, pwrite, rsp_err, r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready} !== 9'b0) begin
            nerr++; $display("FAIL midrst_ctrl: got %b exp 000000000", {psel, penable, busy, pwrite, rsp_err, r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready});
        end
        nvec++; if ({paddr, pwdata, rsp_rdata} !== 48'h0) begin
            nerr++; $display("FAIL midrst_data: got %h exp 0", {paddr, pwdata, rsp_rdata});
        end
        preset = 1'b0;
        model_last = 1; model_rdata = 16'h0000;
        #1;
        nvec++; if ({r0_ready, r1_ready} !== 2'b10) begin
            nerr++; $display("FAIL midrst_tie: got %b exp 10", {r0_ready, r1_ready});
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge pclk); #1;
            if (r0_rsp_valid || r1_rsp_valid || psel) seen = 1'b1;
        end
        nvec++; if (seen !== 1'b0) begin
            nerr++; $display("FAIL midrst_no_rsp: got activity=%b exp 0", seen);
        end
        ws_cfg = 0;
        issue(1'b1, 1'b0, 16'h0033, 16'h0, 1'b1, 1'b0, 16'h0044, 16'h0,
              who, wt, lat, acc, rd, er, rw, both, s1, s2);
        model_apply(model_pick(1'b1, 1'b1), 1'b0, 16'h0033, 16'h0, 1'b0);
        nvec++; if (who !== 0 || rw !== 0 || er !== 1'b0 || rd !== model_rdata) begin
            nerr++; $display("FAIL midrst_after: got who=%0d rsp=%0d err=%b rd=%h exp 0 0 0 %h", who, rw, er, rd, model_rdata);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 5);
        test_reset();
        test_single();
        test_contention();
        test_wait_states();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
